// File: rtl/mux_pkg.sv
// Shared defaults and the flattened-bus word extractor for the round-robin stream mux.
package mux_pkg;

   localparam int MUX_DW_DEFAULT  = 32'd12;
   localparam int MUX_NCH_DEFAULT = 32'd4;

   // Widest word and channel count the extractor bus can carry.
   localparam int MUX_MAX_DW = 32'd64;
   localparam int MUX_MAX_CH = 32'd16;
   localparam int MUX_BUS_W  = MUX_MAX_DW * MUX_MAX_CH;

   // Returns channel idx of a bus packed as idx*dw +: dw; the caller truncates to dw bits.
   function automatic logic [MUX_MAX_DW-1:0] mux_get_word(
      input logic [MUX_BUS_W-1:0] bus,
      input int unsigned          idx,
      input int unsigned          dw
   );
      logic [MUX_BUS_W-1:0] shifted_s;
      shifted_s = bus >> (idx * dw);
      return shifted_s[MUX_MAX_DW-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at NUM_CH-1.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              any
);

   logic             found_s;
   logic [SEL_W:0]   idx_s;

   // Scan ptr, ptr+1, ... with wraparound; the first active request wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx_s = {1'b0, ptr} + (SEL_W+1)'(k);
         if (idx_s >= (SEL_W+1)'(NUM_CH)) begin
            idx_s = idx_s - (SEL_W+1)'(NUM_CH);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s[SEL_W-1:0]]) begin
            found_s = 1'b1;
            gnt_idx = idx_s[SEL_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
      any = en && found_s;
      if (any) begin
         gnt[gnt_idx] = 1'b1;
      end else begin
         gnt = '0;
      end
   end

endmodule

// File: rtl/mux_rr_stream.sv
// NUM_CH-to-1 valid/ready stream mux with round-robin arbitration and a tagged output register.
// Optional MUX_STRICT_PRIO_EN adds prio_mode for fixed lowest-index priority.
module mux_rr_stream
   import mux_pkg::*;
#(
   parameter  int DATA_WIDTH = MUX_DW_DEFAULT,
   parameter  int NUM_CH     = MUX_NCH_DEFAULT,
   localparam int SEL_W      = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       reset_L,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_CH-1:0]          valid_in,
   output logic [NUM_CH-1:0]          ready_out,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [SEL_W-1:0]           ch_out,
   output logic                       valid_out,
   input  logic                       ready_in
`ifdef MUX_STRICT_PRIO_EN
   ,
   input  logic                       prio_mode
`endif
);

   logic [SEL_W-1:0]      ptr_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [SEL_W-1:0]      ch_r;
   logic                  valid_r;

   logic                  load_s;
   logic                  prio_s;
   logic [SEL_W-1:0]      arb_ptr_s;
   logic [NUM_CH-1:0]     gnt_s;
   logic [SEL_W-1:0]      gnt_idx_s;
   logic                  any_s;
   logic [DATA_WIDTH-1:0] word_s;
   logic [SEL_W-1:0]      ptr_next_s;

`ifdef MUX_STRICT_PRIO_EN
   assign prio_s = prio_mode;
`else
   assign prio_s = 1'b0;
`endif

   assign load_s    = !valid_r || ready_in;
   assign arb_ptr_s = prio_s ? '0 : ptr_r;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req     (valid_in),
      .ptr     (arb_ptr_s),
      .en      (load_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s),
      .any     (any_s)
   );

   assign word_s     = DATA_WIDTH'(mux_get_word(MUX_BUS_W'(data_in), 32'(gnt_idx_s),
                                                32'(DATA_WIDTH)));
   assign ptr_next_s = (gnt_idx_s == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx_s + SEL_W'(1);

   // Output register and pointer: load on grant, drain to idle when nothing requests.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ptr_r   <= '0;
         data_r  <= '0;
         ch_r    <= '0;
         valid_r <= 1'b0;
      end else if (load_s) begin
         if (any_s) begin
            data_r  <= word_s;
            ch_r    <= gnt_idx_s;
            valid_r <= 1'b1;
            if (!prio_s) begin
               ptr_r <= ptr_next_s;
            end
         end else begin
            valid_r <= 1'b0;
         end
      end
   end

   // ready_out is gated by reset so no pop reaches the FIFOs while reset_L is low.
   assign ready_out = reset_L ? gnt_s : '0;
   assign data_out  = data_r;
   assign ch_out    = ch_r;
   assign valid_out = valid_r;

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised successor to the fixed 4-input, 12-bit registered mux.
- Merges NUM_CH input streams onto one output stream using valid/ready handshakes and round-robin arbitration.
- Output is registered and tagged with the source channel number.
- Sits between the per-channel FIFOs and the downstream demux/serialiser stage.

Parameters:
- DATA_WIDTH, 12, width of each data word.
- NUM_CH, 4, number of input channels; legal range 2..16; non-power-of-2 supported.
- SEL_W, $clog2(NUM_CH), channel-tag width; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- data_in  input  NUM_CH*DATA_WIDTH  flattened inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  NUM_CH  per-channel request; the word is held stable until accepted.
- ready_out  output  NUM_CH  per-channel accept, one-hot or zero; acts as the pop strobe to the upstream FIFO.
- data_out  output  DATA_WIDTH  registered selected word.
- ch_out  output  SEL_W  registered source channel of data_out.
- valid_out  output  1  data_out holds a valid word.
- ready_in  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect immediately without waiting for a clock edge):
  - valid_out=0, data_out=0, ch_out=0.
  - Round-robin pointer ptr=0, so channel 0 has first priority.
  - ready_out=0 while reset is asserted.
  - Any word held in the output register is dropped.
- load = !valid_out || ready_in. The output register can take a new word this cycle.
- Grant (combinational):
  - When load=1, g = the first i with valid_in[i]=1, searching ptr, ptr+1, ... wrapping after NUM_CH-1 back to 0.
  - ready_out = one-hot(g) if load and any valid_in; otherwise 0.
  - There is a combinational path ready_in -> ready_out; this is accepted by design.
- Rising edge, when load=1 and a grant exists:
  - data_out <= word g; ch_out <= g; valid_out <= 1.
  - ptr <= (g==NUM_CH-1) ? 0 : g+1.
- Rising edge, when load=1 and no request: valid_out <= 0; data_out, ch_out and ptr hold.
- Rising edge, when load=0 (valid_out=1 and ready_in=0): all state holds; ready_out=0.
- Latency: 1 cycle from acceptance to valid_out. Throughput: 1 word per cycle with ready_in held at 1.
- Fairness: with all channels requesting continuously, each channel is granted exactly once in every NUM_CH consecutive grants.
- Simultaneous output drain and refill in the same cycle is lossless; no bubble is inserted.
- Upstream must not change the word on a channel while valid_in is high and no accept has occurred; the block does not check this.
- No X propagation: data_out only loads on a grant.

Optional Feature:
- Macro: MUX_STRICT_PRIO_EN.
- When defined:
  - Adds input port prio_mode (1 bit).
  - When prio_mode=1, g is the lowest-index requesting channel and ptr is not updated.
  - When prio_mode=0, behaviour is round-robin as above.
  - ptr is still cleared by reset.
- When undefined: the port is absent and arbitration is always round-robin; RTL is identical to the prio_mode=0 path.

Decomposition:
- Package mux_pkg:
  - MUX_DW_DEFAULT=12, MUX_NCH_DEFAULT=4.
  - Function to extract channel i from the flattened bus.
- Sub-module rr_arbiter (NUM_CH):
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt, encoded gnt_idx, any.
  - Purely combinational.
- Top module owns ptr and the output register.

Test Plan (DATA_WIDTH=12, NUM_CH=4):
1. Hold reset_L=0 with valid_in=4'hF:
   - Required: valid_out=0, data_out=12'h000, ch_out=0, ready_out=0.
   - Release reset_L: first accepted word is from channel 0.
2. valid_in=4'hF continuous, ready_in=1, words 12'h0A0, 12'h1B1, 12'h2C2, 12'h3D3 on channels 0..3:
   - Required: data_out sequence 0A0, 1B1, 2C2, 3D3, 0A0 on consecutive cycles.
   - Required: ch_out sequence 0, 1, 2, 3, 0 (pointer wrap).
3. Backpressure: ready_in=0 for 3 cycles while valid_out=1 showing 1B1:
   - Required: data_out and ch_out stable, ready_out=4'b0000.
   - Required: on ready_in=1, the next word accepted is 2C2 from channel 2.
4. Sparse requests, valid_in=4'b0101, last grant=2:
   - Required: grants go to channel 0, then channel 2, then channel 0; no grant to idle channels.
   - Then drop valid_in to 0: valid_out falls 1 cycle after the last accepted word drains.
5. Async reset mid-stream: pulse reset_L low between clock edges while valid_out=1:
   - Required: valid_out drops immediately, before the next edge.
   - Required: after release, arbitration restarts at channel 0.
6. With MUX_STRICT_PRIO_EN defined, prio_mode=1 and valid_in=4'hF:
   - Required: channel 0 is granted every cycle.
   - Switch to prio_mode=0: arbitration resumes round-robin from the held ptr.
